// File: rtl/stage_id_pkg.sv
// Shared decode definitions for the ID stage: ALU commands, instruction modes, field positions,
// the registered control bundle, and the control/condition decode helpers.
package stage_id_pkg;

   localparam logic [3:0] ALU_NOP = 4'b0000;
   localparam logic [3:0] ALU_MOV = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_ADC = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_SBC = 4'b0101;
   localparam logic [3:0] ALU_AND = 4'b0110;
   localparam logic [3:0] ALU_ORR = 4'b0111;
   localparam logic [3:0] ALU_EOR = 4'b1000;
   localparam logic [3:0] ALU_MVN = 4'b1001;

   localparam logic [1:0] MODE_ARITH  = 2'b00;
   localparam logic [1:0] MODE_MEM    = 2'b01;
   localparam logic [1:0] MODE_BRANCH = 2'b10;

   localparam int unsigned COND_MSB  = 31;
   localparam int unsigned COND_LSB  = 28;
   localparam int unsigned MODE_MSB  = 27;
   localparam int unsigned MODE_LSB  = 26;
   localparam int unsigned I_BIT     = 25;
   localparam int unsigned OPC_MSB   = 24;
   localparam int unsigned OPC_LSB   = 21;
   localparam int unsigned S_BIT     = 20;
   localparam int unsigned RN_MSB    = 19;
   localparam int unsigned RN_LSB    = 16;
   localparam int unsigned RD_MSB    = 15;
   localparam int unsigned RD_LSB    = 12;
   localparam int unsigned SHOP_MSB  = 11;
   localparam int unsigned IMM24_MSB = 23;
   localparam int unsigned RM_MSB    = 3;

   typedef struct packed {
      logic [3:0] aluCmd;
      logic       memRead;
      logic       memWrite;
      logic       wbEn;
      logic       branch;
      logic       s;
   } ctrl_t;

   typedef struct packed {
      logic [3:0]  aluCmd;
      logic        memRead;
      logic        memWrite;
      logic        wbEn;
      logic        branch;
      logic        s;
      logic        imm;
      logic [11:0] shiftOp;
      logic [23:0] imm24;
   } id_bundle_t;

   function automatic ctrl_t controlUnit(input logic [1:0] mode, input logic [3:0] opcode,
                                         input logic sBit);
      ctrl_t c;
      c = '0;
      case (mode)
         MODE_ARITH: begin
            c.s    = sBit;
            c.wbEn = 1'b1;
            case (opcode)
               4'b1101: c.aluCmd = ALU_MOV;
               4'b1111: c.aluCmd = ALU_MVN;
               4'b0100: c.aluCmd = ALU_ADD;
               4'b0101: c.aluCmd = ALU_ADC;
               4'b0010: c.aluCmd = ALU_SUB;
               4'b0110: c.aluCmd = ALU_SBC;
               4'b0000: c.aluCmd = ALU_AND;
               4'b1100: c.aluCmd = ALU_ORR;
               4'b0001: c.aluCmd = ALU_EOR;
               // CMP/TST only update flags
               4'b1010: begin
                  c.aluCmd = ALU_SUB;
                  c.wbEn   = 1'b0;
               end
               4'b1000: begin
                  c.aluCmd = ALU_AND;
                  c.wbEn   = 1'b0;
               end
               default: begin
                  c.aluCmd = ALU_NOP;
                  c.wbEn   = 1'b0;
               end
            endcase
         end
         MODE_MEM: begin
            c.aluCmd = ALU_ADD;
            if (sBit) begin
               c.memRead = 1'b1;
               c.wbEn    = 1'b1;
            end else begin
               c.memWrite = 1'b1;
            end
         end
         MODE_BRANCH: c.branch = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   // nzcv = {N, Z, C, V}
   function automatic logic conditionCheck(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, ok;
      {n, z, c, v} = nzcv;
      case (cond)
         4'b0000: ok = z;
         4'b0001: ok = ~z;
         4'b0010: ok = c;
         4'b0011: ok = ~c;
         4'b0100: ok = n;
         4'b0101: ok = ~n;
         4'b0110: ok = v;
         4'b0111: ok = ~v;
         4'b1000: ok = c & ~z;
         4'b1001: ok = ~c | z;
         4'b1010: ok = (n == v);
         4'b1011: ok = (n != v);
         4'b1100: ok = ~z & (n == v);
         4'b1101: ok = z | (n != v);
         4'b1110: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: one write port, two asynchronous read ports with optional
// same-cycle write-back bypass. Out-of-range indices read as zero and are never written.
module id_regfile #(
   parameter int unsigned REG_COUNT = 16,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BYPASS_WB = 1,
   localparam int unsigned REG_AW   = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrEn,
   input  logic [REG_AW-1:0] wrAddr,
   input  logic [DATA_W-1:0] wrData,
   input  logic [REG_AW-1:0] rdAddrA,
   output logic [DATA_W-1:0] rdDataA,
   input  logic [REG_AW-1:0] rdAddrB,
   output logic [DATA_W-1:0] rdDataB
);

   localparam logic [REG_AW:0] RegLimit = (REG_AW + 1)'(REG_COUNT);

   logic [DATA_W-1:0] regs [REG_COUNT];
   logic              wrValid;

   assign wrValid = wrEn && ({1'b0, wrAddr} < RegLimit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (wrValid) begin
         regs[wrAddr] <= wrData;
      end
   end

   always_comb begin
      rdDataA = '0;
      if ({1'b0, rdAddrA} < RegLimit) begin
         if ((BYPASS_WB != 0) && wrValid && (wrAddr == rdAddrA)) rdDataA = wrData;
         else rdDataA = regs[rdAddrA];
      end
   end

   always_comb begin
      rdDataB = '0;
      if ({1'b0, rdAddrB} < RegLimit) begin
         if ((BYPASS_WB != 0) && wrValid && (wrAddr == rdAddrB)) rdDataB = wrData;
         else rdDataB = regs[rdAddrB];
      end
   end

endmodule

// File: rtl/stage_id_pipe.sv
// Instruction-decode stage with integrated ID/EX register: decode, operand read, hazard stall,
// flush, and valid/ready flow control on both sides.
module stage_id_pipe
   import stage_id_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_COUNT = 16,
   parameter int unsigned BYPASS_WB = 1,
   localparam int unsigned REG_AW   = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [31:0]       in_inst,
   input  logic              flush,
   input  logic [3:0]        status,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_dest,
   input  logic [DATA_W-1:0] wb_value,
   input  logic              ex_wb_en,
   input  logic [REG_AW-1:0] ex_dest,
   input  logic              mem_wb_en,
   input  logic [REG_AW-1:0] mem_dest,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_rn_val,
   output logic [DATA_W-1:0] out_rm_val,
   output logic [3:0]        out_alu_cmd,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_wb_en,
   output logic              out_branch,
   output logic              out_s,
   output logic              out_imm,
   output logic [11:0]       out_shift_op,
   output logic [23:0]       out_imm24,
   output logic [REG_AW-1:0] out_dest,
   output logic [REG_AW-1:0] out_src1,
   output logic [REG_AW-1:0] out_src2,
   output logic              hazard_stall
);

   logic [3:0] cond, opcode, rn, rd, rm;
   logic [1:0] mode;
   logic       iBit, sBit;

   assign cond   = in_inst[COND_MSB:COND_LSB];
   assign mode   = in_inst[MODE_MSB:MODE_LSB];
   assign iBit   = in_inst[I_BIT];
   assign opcode = in_inst[OPC_MSB:OPC_LSB];
   assign sBit   = in_inst[S_BIT];
   assign rn     = in_inst[RN_MSB:RN_LSB];
   assign rd     = in_inst[RD_MSB:RD_LSB];
   assign rm     = in_inst[RM_MSB:0];

   ctrl_t rawCtrl, ctrl;
   logic  condOk;

   always_comb begin
      rawCtrl = controlUnit(mode, opcode, sBit);
      condOk  = conditionCheck(cond, status);
      ctrl    = condOk ? rawCtrl : '0;
   end

   // Source selection uses the raw decode so a failed-condition store still reports Rd.
   logic [REG_AW-1:0] src1, src2;
   logic              twoSrc, src1Hit, src2Hit, rawHazard, outFree, accept;

   assign src1   = REG_AW'(rn);
   assign src2   = rawCtrl.memWrite ? REG_AW'(rd) : REG_AW'(rm);
   assign twoSrc = ~iBit | rawCtrl.memWrite;

   assign src1Hit   = (ex_wb_en && (ex_dest == src1)) || (mem_wb_en && (mem_dest == src1));
   assign src2Hit   = (ex_wb_en && (ex_dest == src2)) || (mem_wb_en && (mem_dest == src2));
   assign rawHazard = in_valid && condOk && (src1Hit || (twoSrc && src2Hit));

   assign outFree      = ~out_valid | out_ready;
   assign hazard_stall = rawHazard && !flush;
   assign in_ready     = flush || (outFree && !rawHazard);
   assign accept       = in_valid && in_ready && !flush;

   logic [DATA_W-1:0] rnVal, rmVal;

   id_regfile #(
      .REG_COUNT(REG_COUNT),
      .DATA_W   (DATA_W),
      .BYPASS_WB(BYPASS_WB)
   ) uRegfile (
      .clk    (clk),
      .rst    (rst),
      .wrEn   (wb_en),
      .wrAddr (wb_dest),
      .wrData (wb_value),
      .rdAddrA(src1),
      .rdDataA(rnVal),
      .rdAddrB(src2),
      .rdDataB(rmVal)
   );

   logic              validQ, validD;
   id_bundle_t        bundleQ, bundleD;
   logic [DATA_W-1:0] pcQ, pcD, rnQ, rnD, rmQ, rmD;
   logic [REG_AW-1:0] destQ, destD, src1Q, src1D, src2Q, src2D;

   always_comb begin
      validD  = validQ;
      bundleD = bundleQ;
      pcD     = pcQ;
      rnD     = rnQ;
      rmD     = rmQ;
      destD   = destQ;
      src1D   = src1Q;
      src2D   = src2Q;
      if (flush) begin
         validD = 1'b0;
      end else if (outFree) begin
         // A free slot with no accepted instruction becomes a bubble
         validD = accept;
         if (accept) begin
            bundleD.aluCmd   = ctrl.aluCmd;
            bundleD.memRead  = ctrl.memRead;
            bundleD.memWrite = ctrl.memWrite;
            bundleD.wbEn     = ctrl.wbEn;
            bundleD.branch   = ctrl.branch;
            bundleD.s        = ctrl.s;
            bundleD.imm      = iBit;
            bundleD.shiftOp  = in_inst[SHOP_MSB:0];
            bundleD.imm24    = in_inst[IMM24_MSB:0];
            pcD              = in_pc;
            rnD              = rnVal;
            rmD              = rmVal;
            destD            = REG_AW'(rd);
            src1D            = src1;
            src2D            = src2;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         validQ  <= 1'b0;
         bundleQ <= '0;
         pcQ     <= '0;
         rnQ     <= '0;
         rmQ     <= '0;
         destQ   <= '0;
         src1Q   <= '0;
         src2Q   <= '0;
      end else begin
         validQ  <= validD;
         bundleQ <= bundleD;
         pcQ     <= pcD;
         rnQ     <= rnD;
         rmQ     <= rmD;
         destQ   <= destD;
         src1Q   <= src1D;
         src2Q   <= src2D;
      end
   end

   assign out_valid     = validQ;
   assign out_pc        = pcQ;
   assign out_rn_val    = rnQ;
   assign out_rm_val    = rmQ;
   assign out_alu_cmd   = bundleQ.aluCmd;
   assign out_mem_read  = bundleQ.memRead;
   assign out_mem_write = bundleQ.memWrite;
   assign out_wb_en     = bundleQ.wbEn;
   assign out_branch    = bundleQ.branch;
   assign out_s         = bundleQ.s;
   assign out_imm       = bundleQ.imm;
   assign out_shift_op  = bundleQ.shiftOp;
   assign out_imm24     = bundleQ.imm24;
   assign out_dest      = destQ;
   assign out_src1      = src1Q;
   assign out_src2      = src2Q;

endmodule
